// File: rtl/mem_arbiter_if.sv
// Requester and memory bus bundle for mem_arbiter, plus read-only debug taps of its state.
// Handshake: a port holds req_enable_i and payload until req_ready_o is high in the
// same cycle; that cycle is the acceptance, and a read returns req_rvalid_o one cycle later.
interface mem_arbiter_if;
  logic [1:0]  req_enable_i;
  logic [1:0]  req_lock_i;
  logic [7:0]  req_wstrb_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wvalue_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_rvalid_o;
  logic [31:0] req_rvalue_o;
  logic        mem_enable_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wvalue_o;
  logic [31:0] mem_rvalue_i;
  logic        dbg_rr_ptr;
  logic        dbg_lock_valid;
  logic        dbg_lock_owner;
  logic        dbg_rd_pending;
  logic        dbg_rd_owner;

  modport slave (
    input  req_enable_i, req_lock_i, req_wstrb_i, req_addr_i, req_wvalue_i, mem_rvalue_i,
    output req_ready_o, req_rvalid_o, req_rvalue_o,
    output mem_enable_o, mem_wstrb_o, mem_addr_o, mem_wvalue_o,
    output dbg_rr_ptr, dbg_lock_valid, dbg_lock_owner, dbg_rd_pending, dbg_rd_owner
  );

  modport master (
    output req_enable_i, req_lock_i, req_wstrb_i, req_addr_i, req_wvalue_i, mem_rvalue_i,
    input  req_ready_o, req_rvalid_o, req_rvalue_o,
    input  mem_enable_o, mem_wstrb_o, mem_addr_o, mem_wvalue_o,
    input  dbg_rr_ptr, dbg_lock_valid, dbg_lock_owner, dbg_rd_pending, dbg_rd_owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin memory arbiter with per-port bus lock and one-cycle read return routing.
// Request path is purely combinational; only rr pointer, lock and read tag are registered.
module mem_arbiter (
  input  logic          clk_i,
  input  logic          rstn_i,
  mem_arbiter_if.slave  bus
);

  logic       rr_ptr;
  logic       lock_valid;
  logic       lock_owner;
  logic       rd_pending;
  logic       rd_owner;

  logic [1:0] elig;
  logic [1:0] want;
  logic       gnt_valid;
  logic       gnt_port;
  logic [3:0] gnt_wstrb;

  // Requests are masked during reset so every output reads zero while rstn_i is low.
  always_comb begin
    elig      = 2'b11;
    if (lock_valid) elig = lock_owner ? 2'b10 : 2'b01;
    want      = bus.req_enable_i & elig & {2{rstn_i}};
    gnt_valid = |want;
    gnt_port  = (want == 2'b11) ? rr_ptr : want[1];
    gnt_wstrb = gnt_port ? bus.req_wstrb_i[7:4] : bus.req_wstrb_i[3:0];
  end

  always_comb begin
    bus.req_ready_o  = 2'b00;
    bus.mem_enable_o = 1'b0;
    bus.mem_wstrb_o  = 4'h0;
    bus.mem_addr_o   = 32'h0;
    bus.mem_wvalue_o = 32'h0;
    if (gnt_valid) begin
      bus.req_ready_o  = gnt_port ? 2'b10 : 2'b01;
      bus.mem_enable_o = 1'b1;
      bus.mem_wstrb_o  = gnt_wstrb;
      bus.mem_addr_o   = gnt_port ? bus.req_addr_i[63:32]   : bus.req_addr_i[31:0];
      bus.mem_wvalue_o = gnt_port ? bus.req_wvalue_i[63:32] : bus.req_wvalue_i[31:0];
    end
  end

  always_comb begin
    bus.req_rvalid_o = 2'b00;
    bus.req_rvalue_o = 32'h0;
    if (rd_pending) begin
      bus.req_rvalid_o = rd_owner ? 2'b10 : 2'b01;
      bus.req_rvalue_o = bus.mem_rvalue_i;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr     <= 1'b0;
      lock_valid <= 1'b0;
      lock_owner <= 1'b0;
      rd_pending <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      // A release cycle only clears the lock; the grant in that cycle cannot re-arm it.
      if (lock_valid) begin
        if (!bus.req_lock_i[lock_owner]) lock_valid <= 1'b0;
      end else if (gnt_valid) begin
        rr_ptr <= ~gnt_port;
        if (bus.req_lock_i[gnt_port]) begin
          lock_valid <= 1'b1;
          lock_owner <= gnt_port;
        end
      end
      rd_pending <= gnt_valid && (gnt_wstrb == 4'h0);
      if (gnt_valid) rd_owner <= gnt_port;
    end
  end

  assign bus.dbg_rr_ptr     = rr_ptr;
  assign bus.dbg_lock_valid = lock_valid;
  assign bus.dbg_lock_owner = lock_owner;
  assign bus.dbg_rd_pending = rd_pending;
  assign bus.dbg_rd_owner   = rd_owner;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: queue-based reference model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_mem_arbiter;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  mem_arbiter_if bus ();

  mem_arbiter u_dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_rr;      // preferred port
  int         m_lock;    // -1 = no lock, else owning port
  logic [1:0] exp_q[$];  // expected rvalid pattern of the read in flight

  function automatic int pick();
    bit ok0, ok1;
    if (!rstn) return -1;
    ok0 = bus.req_enable_i[0] && (m_lock != 1);
    ok1 = bus.req_enable_i[1] && (m_lock != 0);
    if (ok0 && ok1) return m_rr;
    if (ok0) return 0;
    if (ok1) return 1;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    int g;
    if (!rstn) begin
      m_rr   = 0;
      m_lock = -1;
      exp_q.delete();
    end else begin
      g = pick();
      exp_q.delete();
      if (g >= 0 && ((bus.req_wstrb_i >> (4 * g)) & 8'hF) == 0) exp_q.push_back(2'b01 << g);
      if (m_lock >= 0) begin
        if (!bus.req_lock_i[m_lock]) m_lock = -1;
      end else if (g >= 0) begin
        m_rr = 1 - g;
        if (bus.req_lock_i[g]) m_lock = g;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [1:0]  e_rdy;
    logic [31:0] e_addr, e_wval;
    logic [3:0]  e_strb;
    logic [1:0]  e_rv;
    g      = pick();
    e_rdy  = (g < 0) ? 2'b00 : (2'b01 << g);
    e_addr = (g < 0) ? 32'h0 : 32'(bus.req_addr_i >> (32 * g));
    e_wval = (g < 0) ? 32'h0 : 32'(bus.req_wvalue_i >> (32 * g));
    e_strb = (g < 0) ? 4'h0 : 4'(bus.req_wstrb_i >> (4 * g));
    e_rv   = (exp_q.size() > 0) ? exp_q[0] : 2'b00;
    chk("m_ready",  32'(bus.req_ready_o),  32'(e_rdy));
    chk("m_enable", 32'(bus.mem_enable_o), (g < 0) ? 32'h0 : 32'h1);
    chk("m_addr",   bus.mem_addr_o,        e_addr);
    chk("m_wvalue", bus.mem_wvalue_o,      e_wval);
    chk("m_wstrb",  32'(bus.mem_wstrb_o),  32'(e_strb));
    chk("m_rvalid", 32'(bus.req_rvalid_o), 32'(e_rv));
    chk("m_rvalue", bus.req_rvalue_o,      (e_rv != 0) ? bus.mem_rvalue_i : 32'h0);
    chk("m_rr",     32'(bus.dbg_rr_ptr),   32'(m_rr));
    chk("m_lockv",  32'(bus.dbg_lock_valid), (m_lock >= 0) ? 32'h1 : 32'h0);
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [1:0] en, input logic [1:0] lk, input logic [7:0] ws,
                       input logic [63:0] ad, input logic [63:0] wv, input logic [31:0] rv);
    bus.req_enable_i = en;
    bus.req_lock_i   = lk;
    bus.req_wstrb_i  = ws;
    bus.req_addr_i   = ad;
    bus.req_wvalue_i = wv;
    bus.mem_rvalue_i = rv;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    drive(2'b00, 2'b00, 8'h0, 64'h0, 64'h0, 32'h0);
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    drive(2'b00, 2'b00, 8'h0, 64'h0, 64'h0, 32'h0);
    mid();
    chk("rst_ready",  32'(bus.req_ready_o),  32'h0);
    chk("rst_rvalid", 32'(bus.req_rvalid_o), 32'h0);
    do_reset();

    // Port 0 single read
    drive(2'b01, 2'b00, 8'h00, {32'h0, 32'h100}, 64'h0, 32'h0);
    mid();
    chk("rd_ready", 32'(bus.req_ready_o), 32'h1);
    chk("rd_addr",  bus.mem_addr_o,       32'h100);
    tick();
    drive(2'b00, 2'b00, 8'h00, 64'h0, 64'h0, 32'hDEADBEEF);
    mid();
    chk("rd_rvalid", 32'(bus.req_rvalid_o), 32'h1);
    chk("rd_rvalue", bus.req_rvalue_o,      32'hDEADBEEF);
    tick();

    // Both ports reading continuously
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive((i < 4) ? 2'b11 : 2'b00, 2'b00, 8'h00, {32'h20, 32'h10}, 64'h0, 32'hA000 + i);
      mid();
      if (i < 4) begin
        chk("rr_ready", 32'(bus.req_ready_o), (i % 2) ? 32'h2 : 32'h1);
        chk("rr_addr",  bus.mem_addr_o,       (i % 2) ? 32'h20 : 32'h10);
      end
      if (i > 0) begin
        chk("rr_rvalid", 32'(bus.req_rvalid_o), ((i - 1) % 2) ? 32'h2 : 32'h1);
        chk("rr_rvalue", bus.req_rvalue_o,      32'hA000 + i);
      end
      tick();
    end

    // Port 1 write, port 0 idle
    drive(2'b10, 2'b00, 8'hF0, {32'h40, 32'h0}, {32'hCAFEF00D, 32'h0}, 32'h0);
    mid();
    chk("wr_enable", 32'(bus.mem_enable_o), 32'h1);
    chk("wr_wstrb",  32'(bus.mem_wstrb_o),  32'hF);
    chk("wr_addr",   bus.mem_addr_o,        32'h40);
    chk("wr_wvalue", bus.mem_wvalue_o,      32'hCAFEF00D);
    tick();
    drive(2'b00, 2'b00, 8'h00, 64'h0, 64'h0, 32'h5555);
    mid();
    chk("wr_norvalid", 32'(bus.req_rvalid_o), 32'h0);
    tick();

    // Port 1 locks for three accesses while port 0 keeps requesting
    do_reset();
    drive(2'b10, 2'b10, 8'h00, {32'h80, 32'h8}, 64'h0, 32'h0);
    mid();
    chk("lk_first", 32'(bus.req_ready_o), 32'h2);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(2'b11, 2'b10, 8'h00, {32'h84 + 4 * i, 32'h8}, 64'h0, 32'h0);
      mid();
      chk("lk_hold", 32'(bus.req_ready_o), 32'h2);
      tick();
    end
    drive(2'b01, 2'b00, 8'h00, {32'h0, 32'h8}, 64'h0, 32'h0);
    mid();
    chk("lk_release_cycle", 32'(bus.req_ready_o), 32'h0);
    tick();
    drive(2'b11, 2'b00, 8'h00, {32'h90, 32'h8}, 64'h0, 32'h0);
    mid();
    chk("lk_after_p0", 32'(bus.req_ready_o), 32'h1);
    chk("lk_after_rr", 32'(bus.dbg_rr_ptr),  32'h0);
    tick();
    mid();
    chk("lk_after_p1", 32'(bus.req_ready_o), 32'h2);
    tick();

    // Reset while a read return is pending
    do_reset();
    drive(2'b01, 2'b00, 8'h00, {32'h0, 32'h8}, 64'h0, 32'h0);
    mid();
    chk("rs_accept", 32'(bus.req_ready_o), 32'h1);
    tick();
    drive(2'b11, 2'b00, 8'h00, {32'h20, 32'h8}, 64'h0, 32'h7777);
    rstn = 1'b0;
    mid();
    chk("rs_ready",  32'(bus.req_ready_o),  32'h0);
    chk("rs_rvalid", 32'(bus.req_rvalid_o), 32'h0);
    chk("rs_enable", 32'(bus.mem_enable_o), 32'h0);
    chk("rs_addr",   bus.mem_addr_o,        32'h0);
    chk("rs_rvalue", bus.req_rvalue_o,      32'h0);
    tick();
    rstn = 1'b1;
    mid();
    chk("rs_post_rvalid", 32'(bus.req_rvalid_o), 32'h0);
    chk("rs_post_ready",  32'(bus.req_ready_o),  32'h1);
    tick();
    drive(2'b00, 2'b00, 8'h00, 64'h0, 64'h0, 32'h0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
